// File: rtl/datapath_pkg.sv
// Shared opcode encodings and flag bit positions for the two-stage datapath.
package datapath_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_SHL1  = 3'b101;
    localparam logic [2:0] OP_SHR1  = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;
    localparam int NFLAGS = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus zero/carry/overflow/negative flags.
module alu_core
    import datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]        i_op,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    output logic [WIDTH-1:0]  o_result,
    output logic [NFLAGS-1:0] o_flags
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sum = {1'b0, i_a} + {1'b0, i_b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_res[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra top bit of the widened difference is the borrow (A < B unsigned).
                w_sum = {1'b0, i_a} - {1'b0, i_b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_res[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  w_res = i_a & i_b;
            OP_OR:   w_res = i_a | i_b;
            OP_XOR:  w_res = i_a ^ i_b;
            OP_SHL1: begin
                w_res = {i_a[WIDTH-2:0], 1'b0};
                w_c   = i_a[WIDTH-1];
            end
            OP_SHR1: begin
                w_res = {1'b0, i_a[WIDTH-1:1]};
                w_c   = i_a[0];
            end
            default: w_res = i_b;
        endcase
    end

    assign o_result        = w_res;
    assign o_flags[FLAG_Z] = (w_res == '0);
    assign o_flags[FLAG_C] = w_c;
    assign o_flags[FLAG_V] = w_v;
    assign o_flags[FLAG_N] = w_res[WIDTH-1];

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage pipelined datapath: operand fetch with forwarding, registered ALU result,
// writeback on downstream handoff, valid/ready flow control.
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic             imm_sel,
    input  logic [WIDTH-1:0] imm,
    input  logic [AW-1:0]    rd,
    input  logic             wb_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    input  logic [AW-1:0]    dbg_raddr,
    output logic [WIDTH-1:0] dbg_rdata
);

    logic [WIDTH-1:0]  r_regs [NREGS];

    logic              r_s1_valid;
    logic [2:0]        r_s1_op;
    logic [AW-1:0]     r_s1_rd;
    logic              r_s1_wb;
    logic [WIDTH-1:0]  r_s1_a;
    logic [WIDTH-1:0]  r_s1_b;

    logic              r_s2_valid;
    logic [AW-1:0]     r_s2_rd;
    logic              r_s2_wb;
    logic [WIDTH-1:0]  r_result;
    logic [NFLAGS-1:0] r_flags;

    logic [WIDTH-1:0]  w_alu_res;
    logic [NFLAGS-1:0] w_alu_flags;
    logic [WIDTH-1:0]  w_opa;
    logic [WIDTH-1:0]  w_opb_reg;
    logic              w_s2_free;
    logic              w_s1_adv;
    logic              w_s2_handoff;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .i_op     (r_s1_op),
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .o_result (w_alu_res),
        .o_flags  (w_alu_flags)
    );

    assign w_s2_free    = !r_s2_valid || out_ready;
    assign w_s1_adv     = r_s1_valid && w_s2_free;
    assign w_s2_handoff = r_s2_valid && out_ready;
    assign in_ready     = !r_s1_valid || w_s1_adv;

    // The younger in-flight producer (S1) wins over the older one (S2).
    always_comb begin
        w_opa = '0;
        if (rs1 != '0) begin
            if (r_s1_valid && r_s1_wb && (r_s1_rd == rs1))
                w_opa = w_alu_res;
            else if (r_s2_valid && r_s2_wb && (r_s2_rd == rs1))
                w_opa = r_result;
            else
                w_opa = r_regs[rs1];
        end
    end

    always_comb begin
        w_opb_reg = '0;
        if (rs2 != '0) begin
            if (r_s1_valid && r_s1_wb && (r_s1_rd == rs2))
                w_opb_reg = w_alu_res;
            else if (r_s2_valid && r_s2_wb && (r_s2_rd == rs2))
                w_opb_reg = r_result;
            else
                w_opb_reg = r_regs[rs2];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_rd    <= '0;
            r_s1_wb    <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_rd    <= '0;
            r_s2_wb    <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_op <= op;
                    r_s1_rd <= rd;
                    r_s1_wb <= wb_en;
                    r_s1_a  <= w_opa;
                    r_s1_b  <= imm_sel ? imm : w_opb_reg;
                end
            end
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_rd  <= r_s1_rd;
                    r_s2_wb  <= r_s1_wb;
                    r_result <= w_alu_res;
                    r_flags  <= w_alu_flags;
                end
            end
            if (w_s2_handoff && r_s2_wb && (r_s2_rd != '0))
                r_regs[r_s2_rd] <= r_result;
        end
    end

    assign out_valid  = r_s2_valid;
    assign alu_result = r_result;
    assign zero       = r_flags[FLAG_Z];
    assign carry      = r_flags[FLAG_C];
    assign overflow   = r_flags[FLAG_V];
    assign negative   = r_flags[FLAG_N];
    assign dbg_rdata  = (dbg_raddr == '0) ? '0 : r_regs[dbg_raddr];

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed scoreboard bench for datapath_pipe at 8-bit/8-reg and 16-bit/16-reg configurations.
module tb_datapath_pipe;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                           XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, PASSB = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 8-bit instance
    logic       in_valid = 0, in_ready, imm_sel = 0, wb_en = 0, out_valid, out_ready = 1;
    logic [2:0] op = 0, rs1 = 0, rs2 = 0, rd = 0, dbg_raddr = 0;
    logic [7:0] imm = 0, alu_result, dbg_rdata;
    logic       zero, carry, overflow, negative;

    datapath_pipe #(.WIDTH(8), .NREGS(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rs1(rs1), .rs2(rs2), .imm_sel(imm_sel), .imm(imm), .rd(rd), .wb_en(wb_en),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .zero(zero), .carry(carry), .overflow(overflow), .negative(negative),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    // 16-bit instance
    logic        b_in_valid = 0, b_in_ready, b_imm_sel = 0, b_wb_en = 0, b_out_valid, b_out_ready = 1;
    logic [2:0]  b_op = 0;
    logic [3:0]  b_rs1 = 0, b_rs2 = 0, b_rd = 0, b_dbg_raddr = 0;
    logic [15:0] b_imm = 0, b_alu_result, b_dbg_rdata;
    logic        b_zero, b_carry, b_overflow, b_negative;

    datapath_pipe #(.WIDTH(16), .NREGS(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .op(b_op),
        .rs1(b_rs1), .rs2(b_rs2), .imm_sel(b_imm_sel), .imm(b_imm), .rd(b_rd), .wb_en(b_wb_en),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .alu_result(b_alu_result),
        .zero(b_zero), .carry(b_carry), .overflow(b_overflow), .negative(b_negative),
        .dbg_raddr(b_dbg_raddr), .dbg_rdata(b_dbg_rdata)
    );

    logic [11:0] q  [$];
    logic [19:0] q2 [$];

    // Packed expectation: {result, negative, overflow, carry, zero}
    function automatic logic [11:0] pk(input logic [7:0] r, input logic n, v, c, z);
        return {r, n, v, c, z};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("out8_unexpected", {20'd0, alu_result, negative, overflow, carry, zero}, 32'hFFFF_FFFF);
            end else begin
                logic [11:0] e;
                e = q.pop_front();
                chk("out8", {20'd0, alu_result, negative, overflow, carry, zero}, {20'd0, e});
            end
        end
        if (rst && b_out_valid && b_out_ready) begin
            if (q2.size() == 0) begin
                chk("out16_unexpected", {12'd0, b_alu_result, b_negative, b_overflow, b_carry, b_zero}, 32'hFFFF_FFFF);
            end else begin
                logic [19:0] e2;
                e2 = q2.pop_front();
                chk("out16", {12'd0, b_alu_result, b_negative, b_overflow, b_carry, b_zero}, {12'd0, e2});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                         input logic s, input logic [7:0] im, input logic [2:0] d,
                         input logic w, input logic [11:0] e);
        bit ok = 0;
        op = o; rs1 = a; rs2 = b; imm_sel = s; imm = im; rd = d; wb_en = w; in_valid = 1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; q.push_back(e); end
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk("accept8", {31'd0, ok}, 32'd1);
    endtask

    task automatic issue2(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                          input logic s, input logic [15:0] im, input logic [3:0] d,
                          input logic w, input logic [19:0] e);
        bit ok = 0;
        b_op = o; b_rs1 = a; b_rs2 = b; b_imm_sel = s; b_imm = im; b_rd = d; b_wb_en = w; b_in_valid = 1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (b_in_ready) begin ok = 1; q2.push_back(e); end
            @(posedge clk); #1;
        end
        b_in_valid = 0;
        chk("accept16", {31'd0, ok}, 32'd1);
    endtask

    task automatic dbg(input logic [2:0] a, input logic [7:0] e);
        dbg_raddr = a;
        @(negedge clk);
        chk($sformatf("dbg8_R%0d", a), {24'd0, dbg_rdata}, {24'd0, e});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        rst = 1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result_flags", {20'd0, alu_result, negative, overflow, carry, zero}, 32'd0);
        @(posedge clk); #1;
        dbg(3'd1, 8'h00);

        // Back-to-back issue of immediates and a dependent add
        issue(PASSB, 0, 0, 1, 8'd10, 3'd1, 1, pk(8'd10, 0, 0, 0, 0));
        issue(PASSB, 0, 0, 1, 8'd5,  3'd2, 1, pk(8'd5,  0, 0, 0, 0));
        issue(ADD,   1, 2, 0, 8'd0,  3'd3, 1, pk(8'd15, 0, 0, 0, 0));
        step(4);
        dbg(3'd3, 8'd15);

        issue(SUB, 2, 1, 0, 8'd0, 3'd6, 0, pk(8'hFB, 1, 0, 1, 0));
        issue(SUB, 1, 1, 0, 8'd0, 3'd6, 0, pk(8'h00, 0, 0, 0, 1));
        step(4);

        // S1 forwarding, then S2 forwarding with one idle cycle
        issue(PASSB, 0, 0, 1, 8'h7F, 3'd4, 1, pk(8'h7F, 0, 0, 0, 0));
        issue(ADD,   4, 4, 0, 8'd0,  3'd5, 1, pk(8'hFE, 1, 1, 0, 0));
        step(4);
        issue(PASSB, 0, 0, 1, 8'h7F, 3'd6, 1, pk(8'h7F, 0, 0, 0, 0));
        step(1);
        issue(ADD,   6, 6, 0, 8'd0,  3'd7, 1, pk(8'hFE, 1, 1, 0, 0));
        step(4);
        dbg(3'd7, 8'hFE);

        // Backpressure: two accepted, third blocked, output held stable
        out_ready = 0;
        issue(AND_, 5, 0, 1, 8'h0F, 3'd1, 1, pk(8'h0E, 0, 0, 0, 0));
        issue(OR_,  1, 2, 0, 8'd0,  3'd2, 1, pk(8'h0F, 0, 0, 0, 0));
        op = XOR_; rs1 = 2; rs2 = 4; imm_sel = 0; rd = 3; wb_en = 1; in_valid = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_hold", {20'd0, alu_result, negative, overflow, carry, zero}, {20'd0, pk(8'h0E, 0, 0, 0, 0)});
            @(posedge clk); #1;
        end
        out_ready = 1;
        issue(XOR_, 2, 4, 0, 8'd0, 3'd3, 1, pk(8'h70, 0, 0, 0, 0));
        step(5);
        chk("stall_drained", q.size(), 32'd0);
        dbg(3'd3, 8'h70);

        // R0 is hardwired to zero; shifts
        issue(PASSB, 0, 0, 1, 8'hAA, 3'd0, 1, pk(8'hAA, 1, 0, 0, 0));
        issue(ADD,   0, 0, 0, 8'd0,  3'd7, 0, pk(8'h00, 0, 0, 0, 1));
        issue(PASSB, 0, 0, 1, 8'h81, 3'd1, 1, pk(8'h81, 1, 0, 0, 0));
        issue(SHL,   1, 0, 0, 8'd0,  3'd2, 1, pk(8'h02, 0, 0, 1, 0));
        issue(PASSB, 0, 0, 1, 8'h01, 3'd3, 1, pk(8'h01, 0, 0, 0, 0));
        issue(SHR,   3, 0, 0, 8'd0,  3'd4, 1, pk(8'h00, 0, 0, 1, 1));
        step(4);
        dbg(3'd0, 8'h00);
        dbg(3'd2, 8'h02);

        // Reset with both stages occupied
        out_ready = 0;
        issue(PASSB, 0, 0, 1, 8'h33, 3'd4, 1, pk(8'h33, 0, 0, 0, 0));
        issue(PASSB, 0, 0, 1, 8'h44, 3'd5, 1, pk(8'h44, 0, 0, 0, 0));
        rst = 0;
        step(1);
        rst = 1;
        q.delete();
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1;
        for (int i = 0; i < 8; i++) dbg(i[2:0], 8'h00);

        // 16-bit / 16-register configuration
        issue2(PASSB, 0, 0, 1, 16'd10,    4'd1,  1, {16'd10, 4'b0000});
        issue2(PASSB, 0, 0, 1, 16'd5,     4'd2,  1, {16'd5,  4'b0000});
        issue2(ADD,   1, 2, 0, 16'd0,     4'd3,  1, {16'd15, 4'b0000});
        issue2(PASSB, 0, 0, 1, 16'h1234,  4'd15, 1, {16'h1234, 4'b0000});
        issue2(ADD,  15, 15, 0, 16'd0,    4'd14, 1, {16'h2468, 4'b0000});
        step(4);
        b_dbg_raddr = 4'd3;
        @(negedge clk);
        chk("dbg16_R3", {16'd0, b_dbg_rdata}, 32'd15);
        @(posedge clk); #1;
        b_dbg_raddr = 4'd14;
        @(negedge clk);
        chk("dbg16_R14", {16'd0, b_dbg_rdata}, 32'h2468);
        chk("q8_empty", q.size(), 32'd0);
        chk("q16_empty", q2.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
